// File: rtl/ss_dfifo_pkg.sv
// Shared definitions for the ss_dfifo read-data buffer.
// Defining SS_DFIFO_BYTESWAP_EN reverses the bytes of each 32-bit word as it enters the FIFO.
package ss_dfifo_pkg;
  localparam logic [2:0] S_B_WAIT = 3'h4;
  localparam int ENTRY_W = 65;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT} st_t;

  typedef struct packed {
    logic        last;
    logic [31:0] hi;
    logic [31:0] lo;
  } entry_t;

  function automatic logic [31:0] word_in(input logic [31:0] w);
`ifdef SS_DFIFO_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction
endpackage

// File: rtl/ss_dfifo_ram.sv
// DEPTH x W storage for ss_dfifo: one synchronous write port, one asynchronous read port.
module ss_dfifo_ram #(
  parameter int AW = 4,
  parameter int W  = 65
) (
  input  logic          wb_clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [(1<<AW)-1:0][W-1:0] mem;

  always_ff @(posedge wb_clk_i)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/ss_dfifo.sv
// Read-data buffer behind ss_sg: captures acked beats, streams them out, paces ss_sg bursts.
// Byte-lane order of stored data is selected by SS_DFIFO_BYTESWAP_EN (see ss_dfifo_pkg).
module ss_dfifo
  import ss_dfifo_pkg::*;
#(
  parameter int AW          = 4,
  parameter int BURST       = 8,
  parameter int STOP_MARGIN = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          en,
  input  logic          abort,
  input  logic [31:0]   wbs_dat_o,
  input  logic [31:0]   wbs_dat64_o,
  input  logic          ss_xfer,
  input  logic          ss_last,
  input  logic [7:0]    sg_state,
  input  logic          c_done,
  output logic          ss_start,
  output logic          ss_stop,
  output logic          ss_end,
  output logic [63:0]   m_dat,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   fifo_cnt,
  output logic          ovf
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(1 << AW);

  st_t           state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_inc;
  logic [AW:0]   count, free;
  logic          start_q, full, wr_en, pop, flush, job_start;
  logic          sg_unused;
  entry_t        wentry, rentry;

  assign sg_unused = &{1'b0, sg_state[6:3]};

  assign full       = (count == DEPTH_C);
  assign free       = DEPTH_C - count;
  assign wr_en      = ss_xfer & ~full;
  assign wr_ptr_inc = wr_ptr + 1'b1;
  assign m_valid    = (count != '0);
  assign pop        = m_valid & m_ready;
  assign flush      = (state == S_ABORT) & c_done;
  assign job_start  = (state == S_IDLE) & en;

  assign wentry = '{last: ss_last & sg_state[7],
                    hi:   word_in(wbs_dat64_o),
                    lo:   word_in(wbs_dat_o)};

  ss_dfifo_ram #(.AW(AW), .W(ENTRY_W)) u_ram (
    .wb_clk_i (wb_clk_i),
    .we       (wr_en),
    .waddr    (wr_ptr),
    .wdata    (wentry),
    .raddr    (rd_ptr),
    .rdata    (rentry)
  );

  // Storage is never reset, so m_last is qualified by occupancy.
  assign m_dat    = {rentry.hi, rentry.lo};
  assign m_last   = m_valid & rentry.last;
  assign fifo_cnt = count;
  assign ss_stop  = free <= (AW+1)'(STOP_MARGIN);

  always_comb begin
    state_nxt = state;
    ss_start  = 1'b0;
    ss_end    = 1'b0;
    case (state)
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN: begin
        ss_start = (sg_state[2:0] == S_B_WAIT) && (free >= (AW+1)'(BURST)) && !start_q;
        if (abort)                    state_nxt = S_ABORT;
        else if (pop && rentry.last)  state_nxt = S_IDLE;
        else if (!en)                 state_nxt = S_IDLE;
      end
      S_ABORT: begin
        ss_end = 1'b1;
        if (c_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      start_q <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= ss_start;
      if (wr_en) wr_ptr <= wr_ptr_inc;
      // A beat landing in the flush cycle is discarded with the rest of the job.
      if (flush) begin
        rd_ptr <= wr_en ? wr_ptr_inc : wr_ptr;
        count  <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (job_start)       ovf <= 1'b0;
      if (ss_xfer && full) ovf <= 1'b1;
    end
  end
endmodule
